// File: rtl/can_id_transmitter.sv
// can_id_transmitter: shifts a locally owned CAN identifier onto the bus MSB first and
// checks each driven bit against a 2-of-3 majority of the bus readback samples.
module can_id_transmitter #(
    parameter int LENGTH   = 12,
    parameter int ID_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         start,
    input  logic [ID_WIDTH-1:0]          id,
    input  logic                         txPulse,
    input  logic                         samplePulse,
    input  logic                         dIn,
    output logic                         dOut,
    output logic                         busy,
    output logic                         txComplete,
    output logic                         arbLost,
    output logic                         bitError,
    output logic [$clog2(LENGTH+1)-1:0]  bitCount
);
    localparam int CW = $clog2(LENGTH+1);
    localparam logic [CW-1:0] LAST = CW'(LENGTH);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_TX, SAMPLE, CHECK, DONE, LOST, ERROR} state_t;
    state_t            state, state_n;
    logic [LENGTH-1:0] shift_reg, shift_n;
    logic [1:0]        samp_cnt, samp_cnt_n;
    logic [2:0]        samples, samples_n;
    logic [CW-1:0]     cnt_n;
    logic              dout_n, tc_n, al_n, be_n, voted, unused_id;
    assign voted = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    assign unused_id = ^id;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            shift_reg  <= '0;
            samp_cnt   <= '0;
            samples    <= '0;
            bitCount   <= '0;
            dOut       <= 1'b1;
            busy       <= 1'b0;
            txComplete <= 1'b0;
            arbLost    <= 1'b0;
            bitError   <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            samp_cnt   <= samp_cnt_n;
            samples    <= samples_n;
            bitCount   <= cnt_n;
            dOut       <= dout_n;
            busy       <= state_n inside {LOAD, WAIT_TX, SAMPLE, CHECK};
            txComplete <= tc_n;
            arbLost    <= al_n;
            bitError   <= be_n;
        end
    end
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        samp_cnt_n = samp_cnt;
        samples_n  = samples;
        cnt_n      = bitCount;
        dout_n     = dOut;
        tc_n       = txComplete;
        al_n       = arbLost;
        be_n       = bitError;
        if (!enable) begin
            state_n = IDLE;
            dout_n  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    dout_n = 1'b1;
                    if (start) begin
                        state_n = LOAD;
                        shift_n = id[LENGTH-1:0];
                        cnt_n   = '0;
                        tc_n    = 1'b0;
                        al_n    = 1'b0;
                        be_n    = 1'b0;
                    end
                end
                LOAD: state_n = WAIT_TX;
                WAIT_TX: if (txPulse) begin
                    dout_n     = shift_reg[LENGTH-1];
                    shift_n    = shift_reg << 1;
                    cnt_n      = bitCount + 1'b1;
                    samp_cnt_n = '0;
                    state_n    = SAMPLE;
                end
                SAMPLE: if (samplePulse) begin
                    samples_n[samp_cnt] = dIn;
                    samp_cnt_n          = samp_cnt + 1'b1;
                    state_n             = (samp_cnt == 2'd2) ? CHECK : SAMPLE;
                end
                // dOut still carries the bit driven for this bit time
                CHECK: begin
                    if (dOut && !voted) begin
                        al_n    = 1'b1;
                        dout_n  = 1'b1;
                        state_n = LOST;
                    end else if (!dOut && voted) begin
                        be_n    = 1'b1;
                        dout_n  = 1'b1;
                        state_n = ERROR;
                    end else if (bitCount == LAST) begin
                        tc_n    = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WAIT_TX;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_can_id_transmitter.sv
// tb_can_id_transmitter: table vectors, hand sequences and randomized frames checked against a bit-level model.
module tb_can_id_transmitter;
    localparam int L = 12;
    logic clk = 0, resetN = 0, enable = 0, start = 0, txPulse = 0, samplePulse = 0, dIn = 1;
    logic [31:0] id = '0;
    logic dOut, busy, txComplete, arbLost, bitError;
    logic [3:0] bitCount;
    int checks = 0, failures = 0;
    logic last_tc = 0, last_al = 0, last_be = 0;
    typedef struct {
        logic [31:0] idv;
        logic [35:0] fl;
        int          cnt;
        logic        tc, al, be, dv;
    } vec_t;
    vec_t tbl[10];

    can_id_transmitter #(.LENGTH(L), .ID_WIDTH(32)) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .start(start), .id(id),
        .txPulse(txPulse), .samplePulse(samplePulse), .dIn(dIn), .dOut(dOut),
        .busy(busy), .txComplete(txComplete), .arbLost(arbLost), .bitError(bitError),
        .bitCount(bitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic tx, input logic sp, input logic d);
        txPulse = tx;
        samplePulse = sp;
        dIn = d;
        @(negedge clk);
        txPulse = 0;
        samplePulse = 0;
    endtask

    // One bit time: txPulse, gap, three readback samples (bus = dOut xor flip), then the CHECK cycle.
    task automatic bit_cycle(input logic [2:0] fl, input bit stray, output logic seen);
        cyc(1'b1, 1'b0, 1'b1);
        seen = dOut;
        cyc(1'b0, 1'b0, dOut);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 1'b1, dOut ^ fl[j]);
            if (j < 2) cyc(stray, 1'b0, dOut);
        end
        cyc(1'b0, 1'b0, dOut);
    endtask

    task automatic send_bits(input logic [35:0] fl, input bit stray, output logic [L-1:0] seen);
        logic s;
        for (int k = 0; k < L; k++) begin
            bit_cycle(fl[k*3 +: 3], stray, s);
            seen[L-1-k] = s;
        end
    endtask

    task automatic idle(input string nm);
        enable = 0;
        start = 0;
        @(negedge clk);
        chk({nm, "_idle_dout"}, 32'(dOut), 1);
        chk({nm, "_idle_busy"}, 32'(busy), 0);
        chk({nm, "_sticky"}, {29'b0, txComplete, arbLost, bitError}, {29'b0, last_tc, last_al, last_be});
    endtask

    task automatic do_start(input string nm, input logic [31:0] idv);
        enable = 1;
        id = idv;
        start = 1;
        @(negedge clk);
        start = 0;
        id = $urandom;
        chk({nm, "_load_busy"}, 32'(busy), 1);
        chk({nm, "_load_flags"}, {29'b0, txComplete, arbLost, bitError}, 0);
        chk({nm, "_load_cnt"}, 32'(bitCount), 0);
        chk({nm, "_load_dout"}, 32'(dOut), 1);
        @(negedge clk);
    endtask

    task automatic check_end(input string nm, input logic [L-1:0] idv, input logic [L-1:0] seen,
                             input int cnt, input logic tc, input logic al, input logic be, input logic dv);
        chk({nm, "_cnt"}, 32'(bitCount), cnt);
        chk({nm, "_tc"}, 32'(txComplete), 32'(tc));
        chk({nm, "_al"}, 32'(arbLost), 32'(al));
        chk({nm, "_be"}, 32'(bitError), 32'(be));
        chk({nm, "_dout"}, 32'(dOut), 32'(dv));
        chk({nm, "_busy"}, 32'(busy), 0);
        for (int i = 0; i < cnt; i++) chk({nm, "_seq"}, 32'(seen[L-1-i]), 32'(idv[L-1-i]));
        last_tc = tc;
        last_al = al;
        last_be = be;
    endtask

    // Reference: bit k sends id[L-1-k]; a bit is misread when at least two of its three samples are flipped.
    function automatic void model(input logic [L-1:0] idv, input logic [35:0] fl, output int cnt,
                                  output logic tc, output logic al, output logic be, output logic dv);
        cnt = L; tc = 1; al = 0; be = 0;
        for (int k = 0; k < L; k++) begin
            if ($countones(fl[k*3 +: 3]) >= 2) begin
                cnt = k + 1; tc = 0; al = idv[L-1-k]; be = !idv[L-1-k];
                break;
            end
        end
        dv = (al || be) ? 1'b1 : idv[0];
    endfunction

    initial begin
        logic [L-1:0] seen;
        logic s;
        logic [31:0] idv;
        logic [35:0] fl;
        int cnt;
        logic tc, al, be, dv;
        tbl[0] = '{32'h0A5, 36'h0, 12, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'h0A5, 36'h7000, 5, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h0A5, 36'h7, 1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{32'h0A5, 36'h5000, 5, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{32'h0A5, 36'h2000, 12, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h7FF, 36'h0, 12, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'h000, 36'h600000000, 12, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{32'hFFF, 36'h6, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{32'hDEADB5A4, 36'h0, 12, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'h5A4, 36'h38, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dOut), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'b0, txComplete, arbLost, bitError}, 0);
        chk("rst_cnt", 32'(bitCount), 0);
        resetN = 1;
        @(negedge clk);
        for (int v = 0; v < 10; v++) begin
            idle("tbl");
            do_start("tbl", tbl[v].idv);
            send_bits(tbl[v].fl, 1'b0, seen);
            check_end("tbl", tbl[v].idv[L-1:0], seen, tbl[v].cnt, tbl[v].tc, tbl[v].al, tbl[v].be, tbl[v].dv);
        end
        // Bit error on SOF: flag and recessive release land one cycle after CHECK.
        idle("be");
        do_start("be", 32'h0A5);
        cyc(1'b1, 1'b0, 1'b1);
        chk("be_drive", 32'(dOut), 0);
        chk("be_cnt_inc", 32'(bitCount), 1);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        chk("be_check_flag", 32'(bitError), 0);
        chk("be_check_dout", 32'(dOut), 0);
        chk("be_check_busy", 32'(busy), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("be_flag", 32'(bitError), 1);
        chk("be_release", 32'(dOut), 1);
        chk("be_busy", 32'(busy), 0);
        chk("be_tc", 32'(txComplete), 0);
        bit_cycle(3'b000, 1'b0, s);
        chk("be_hold_dout", 32'(dOut), 1);
        chk("be_hold_cnt", 32'(bitCount), 1);
        last_tc = 0; last_al = 0; last_be = 1;
        // Abort on a dominant bit, then restart with 0x7FF.
        idle("abort");
        do_start("abort", 32'h0A5);
        for (int k = 0; k < 5; k++) bit_cycle(3'b000, 1'b0, s);
        cyc(1'b1, 1'b0, 1'b1);
        chk("abort_drive", 32'(dOut), 0);
        last_tc = 0; last_al = 0; last_be = 0;
        idle("abort");
        do_start("restart", 32'h7FF);
        send_bits(36'h0, 1'b0, seen);
        check_end("restart", 12'h7FF, seen, 12, 1'b1, 1'b0, 1'b0, 1'b1);
        // Asynchronous reset while driving dominant bit 3.
        idle("rst");
        do_start("rst", 32'h0A5);
        for (int k = 0; k < 3; k++) bit_cycle(3'b000, 1'b0, s);
        cyc(1'b1, 1'b0, 1'b1);
        chk("rst_mid_drive", 32'(dOut), 0);
        #2 resetN = 0;
        #1;
        chk("rst_mid_dout", 32'(dOut), 1);
        chk("rst_mid_cnt", 32'(bitCount), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_flags", {29'b0, txComplete, arbLost, bitError}, 0);
        @(negedge clk);
        resetN = 1;
        @(negedge clk);
        // A second start while busy must not reload the identifier.
        do_start("ign", 32'h0A5);
        id = 32'hFFF;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("ign_busy", 32'(busy), 1);
        send_bits(36'h0, 1'b0, seen);
        check_end("ign", 12'h0A5, seen, 12, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 40; r++) begin
            idv = $urandom;
            fl = '0;
            for (int k = 0; k < L; k++) if ($urandom_range(0, 9) == 0) fl[k*3 +: 3] = 3'($urandom);
            model(idv[L-1:0], fl, cnt, tc, al, be, dv);
            idle("rnd");
            do_start("rnd", idv);
            send_bits(fl, 1'($urandom), seen);
            check_end("rnd", idv[L-1:0], seen, cnt, tc, al, be, dv);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
